// File: rtl/vpattern_axis_out.sv
// vpattern_axis_out: output stage for the vpattern_gen pattern generator.
// Counts pixels/lines of the raw generator stream, tags each pixel with
// AXI4-Stream video sideband (tuser = start of frame, tlast = end of line),
// buffers the tagged pixels in a first-word-fall-through FIFO and raises a
// sticky flag on frame-sync errors.
// Optional feature macro: VPATTERN_AXIS_FRAME_CNT_EN adds the 32-bit
// completed-frame counter and its frame_cnt port.
module vpattern_axis_out #(
  parameter int DATA_WIDTH = 24,
  parameter int H_ACTIVE   = 1920,
  parameter int V_ACTIVE   = 1080,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  enable,
  input  logic                  clr_err,
  input  logic [DATA_WIDTH-1:0] s_pix_data,
  input  logic                  s_pix_valid,
  input  logic                  s_pix_sof,
  output logic                  s_pix_ready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  sync_err
`ifdef VPATTERN_AXIS_FRAME_CNT_EN
  ,
  output logic [31:0]           frame_cnt
`endif
);

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_WIDTH + 2;

  localparam logic [XW-1:0] X_LAST     = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] FULL_LEVEL = CW'(FIFO_DEPTH);

  typedef enum logic {
    WAIT_SOF,
    ACTIVE
  } state_e;

  state_e state_q, state_d;
  logic [XW-1:0] xCnt_q, xCnt_d, xCur;
  logic [YW-1:0] yCnt_q, yCnt_d, yCur;
  logic          pixAccept;
  logic          fifoPush, fifoPop, fifoFull, fifoEmpty;
  logic          tagUser, tagLast, errSet;
  logic          syncErr_q, syncErr_d;

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic [EW-1:0] headEntry;

  // A full FIFO blocks new pixels even when the head is popping in the same
  // cycle, and nothing is accepted while the block is held in reset.
  assign fifoFull    = (count_q == FULL_LEVEL);
  assign fifoEmpty   = (count_q == '0);
  assign s_pix_ready = enable && !fifoFull && !ARESET;
  assign pixAccept   = s_pix_valid && s_pix_ready;
  assign fifoPop     = !fifoEmpty && m_axis_tready;

  // Tagger next state: a SOF pixel always restarts the counters at (0,0);
  // other pixels are either dropped (no frame open) or tagged at the current
  // position, and the last pixel of the last line closes the frame.
  always_comb begin
    state_d  = state_q;
    xCnt_d   = xCnt_q;
    yCnt_d   = yCnt_q;
    xCur     = xCnt_q;
    yCur     = yCnt_q;
    fifoPush = 1'b0;
    tagUser  = 1'b0;
    tagLast  = 1'b0;
    errSet   = 1'b0;
    if (!enable) begin
      state_d = WAIT_SOF;
      xCnt_d  = '0;
      yCnt_d  = '0;
    end else if (pixAccept) begin
      if (s_pix_sof || (state_q == ACTIVE)) begin
        fifoPush = 1'b1;
        if (s_pix_sof) begin
          xCur    = '0;
          yCur    = '0;
          tagUser = 1'b1;
          errSet  = (state_q == ACTIVE);
        end
        tagLast = (xCur == X_LAST);
        if (tagLast) begin
          xCnt_d = '0;
          if (yCur == Y_LAST) begin
            yCnt_d  = '0;
            state_d = WAIT_SOF;
          end else begin
            yCnt_d  = yCur + 1'b1;
            state_d = ACTIVE;
          end
        end else begin
          xCnt_d  = xCur + 1'b1;
          yCnt_d  = yCur;
          state_d = ACTIVE;
        end
      end else begin
        errSet = 1'b1;
      end
    end
  end

  // Tagger state and position counters.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= WAIT_SOF;
      xCnt_q  <= '0;
      yCnt_q  <= '0;
    end else begin
      state_q <= state_d;
      xCnt_q  <= xCnt_d;
      yCnt_q  <= yCnt_d;
    end
  end

  // Sticky sync error: a new error wins over a clear arriving in the same cycle.
  assign syncErr_d = errSet ? 1'b1 : (clr_err ? 1'b0 : syncErr_q);

  // Sync error register.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      syncErr_q <= 1'b0;
    end else begin
      syncErr_q <= syncErr_d;
    end
  end

  assign sync_err = syncErr_q;

  // FIFO pointer and occupancy next state; pointers wrap at the power-of-2 depth.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (fifoPush) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (fifoPop) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    case ({fifoPush, fifoPop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO control registers; reset discards whatever was queued.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // FIFO storage, entries packed as {tuser, tlast, data}.
  always_ff @(posedge ACLK) begin
    if (fifoPush) begin
      mem_q[wrPtr_q] <= {tagUser, tagLast, s_pix_data};
    end
  end

  // The head entry is held until popped, so the sideband stays stable while
  // stalled; outputs read as zero whenever the FIFO is empty.
  assign headEntry     = mem_q[rdPtr_q];
  assign m_axis_tvalid = !fifoEmpty;
  assign m_axis_tdata  = fifoEmpty ? '0 : headEntry[DATA_WIDTH-1:0];
  assign m_axis_tlast  = !fifoEmpty && headEntry[DATA_WIDTH];
  assign m_axis_tuser  = !fifoEmpty && headEntry[DATA_WIDTH+1];

`ifdef VPATTERN_AXIS_FRAME_CNT_EN
  logic        frameDone;
  logic [31:0] frameCnt_q, frameCnt_d;

  // Only the natural end of a frame counts; a resync-truncated frame never
  // reaches its last pixel, so it is never counted.
  assign frameDone  = fifoPush && tagLast && (yCur == Y_LAST);
  assign frameCnt_d = frameCnt_q + {31'd0, frameDone};

  // Completed-frame counter, wrapping naturally at 32 bits.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      frameCnt_q <= '0;
    end else begin
      frameCnt_q <= frameCnt_d;
    end
  end

  assign frame_cnt = frameCnt_q;
`endif

endmodule
